// File: rtl/branch_update_queue_if.sv
// -----------------------------------------------------------------------------
// branch_update_queue_if
//   Handshake bundle between the dual-issue EX stage, the branch update queue
//   and the branch predictor lite.
//
//   Push side (EX -> queue):
//     res0_valid / res0_info  : older resolved branch
//     res1_valid / res1_info  : younger resolved branch
//     res_ready               : queue can take two pushes this cycle
//   Update side (queue -> predictor):
//     upd_valid / branch_info_o : head entry (all zero when not valid)
//     upd_ready                 : predictor consumes the head this cycle
//
//   modport slave  : used by the queue itself
//   modport master : used by the surrounding EX/predictor environment
// -----------------------------------------------------------------------------
interface branch_update_queue_if #(
  parameter int INFO_W = 67
);
  logic              res0_valid;
  logic [INFO_W-1:0] res0_info;
  logic              res1_valid;
  logic [INFO_W-1:0] res1_info;
  logic              res_ready;
  logic              upd_ready;
  logic              upd_valid;
  logic [INFO_W-1:0] branch_info_o;

  modport slave (
    input  res0_valid, res0_info, res1_valid, res1_info, upd_ready,
    output res_ready, upd_valid, branch_info_o
  );

  modport master (
    output res0_valid, res0_info, res1_valid, res1_info, upd_ready,
    input  res_ready, upd_valid, branch_info_o
  );
endinterface

// File: rtl/branch_update_queue.sv
// -----------------------------------------------------------------------------
// branch_update_queue
//   In-order FIFO between the dual-issue EX stage and the branch predictor.
//   Accepts up to two resolved branches per cycle (slot0 older than slot1) and
//   presents at most one packed branch_info word per cycle. An all-zero word
//   with upd_valid=0 means "no update".
//
//   branch_info layout: {pc[66:35], taken[34], target[33:2], btype[1:0]}
//
//   Ports:
//     clk, resetn  : clock, asynchronous active-low reset
//     flush        : synchronous clear of all queued entries
//     bus (slave)  : push and update handshakes (see branch_update_queue_if)
//     count_o      : occupied entries
//     drop_cnt_o   : saturating count of pushes lost to overflow
//
//   Optional feature macro: BUQ_EMPTY_BYPASS_EN
//     Defined  : when empty, the oldest incoming entry is forwarded
//                combinationally to the predictor in the same cycle.
//     Undefined: outputs depend on registered state only (1-cycle latency).
// -----------------------------------------------------------------------------
module branch_update_queue #(
  parameter int DEPTH  = 8,
  parameter int PTR_W  = 3,
  parameter int INFO_W = 67
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 flush,
  branch_update_queue_if.slave bus,
  output logic [PTR_W:0]       count_o,
  output logic [15:0]          drop_cnt_o
);

  localparam logic [PTR_W:0] DEPTH_C = DEPTH[PTR_W:0];
  localparam logic [PTR_W:0] TWO_C   = (PTR_W+1)'(2);
  localparam logic [PTR_W:0] ONE_C   = (PTR_W+1)'(1);

  logic [INFO_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W:0]    count;

  logic [1:0]        in_cnt;
  logic [INFO_W-1:0] first_info;
  logic [INFO_W-1:0] wr0_info;
  logic              mem_pop;
  logic              byp_take;
  logic [1:0]        req;
  logic [1:0]        accept;
  logic [1:0]        dropped;
  logic [PTR_W:0]    free;
  logic [16:0]       drop_sum;
  logic [15:0]       drop_next;

  // Output side: head of the array, optionally replaced by the oldest
  // incoming entry while the queue is empty. byp_take marks that the
  // predictor consumed that forwarded entry, so it must not be written.
  always_comb begin
    in_cnt     = 2'(bus.res0_valid) + 2'(bus.res1_valid);
    first_info = bus.res0_valid ? bus.res0_info : bus.res1_info;
    mem_pop    = (count != '0) && bus.upd_ready;
`ifdef BUQ_EMPTY_BYPASS_EN
    bus.upd_valid = (count != '0) || ((in_cnt != 2'd0) && !flush);
    if (count != '0)
      bus.branch_info_o = mem[rd_ptr];
    else if (bus.upd_valid)
      bus.branch_info_o = first_info;
    else
      bus.branch_info_o = '0;
    byp_take = (count == '0) && (in_cnt != 2'd0) && !flush && bus.upd_ready;
`else
    bus.upd_valid     = (count != '0);
    bus.branch_info_o = bus.upd_valid ? mem[rd_ptr] : '0;
    byp_take          = 1'b0;
`endif
    bus.res_ready = (count <= DEPTH_C - TWO_C);
  end

  // Push accounting: pushes are taken in age order into the space left after
  // this cycle's pop; anything beyond that is dropped and counted.
  always_comb begin
    if (byp_take) begin
      req      = in_cnt - 2'd1;
      wr0_info = bus.res1_info;
    end else begin
      req      = in_cnt;
      wr0_info = first_info;
    end
    free = DEPTH_C - count + {{PTR_W{1'b0}}, mem_pop};
    if (free >= TWO_C)
      accept = req;
    else if ((free == ONE_C) && (req != 2'd0))
      accept = 2'd1;
    else
      accept = 2'd0;
    dropped   = req - accept;
    drop_sum  = {1'b0, drop_cnt_o} + 17'(dropped);
    drop_next = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  // Pointer, occupancy and drop counter state. Flush clears the queue but
  // deliberately leaves the drop counter alone.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      drop_cnt_o <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr     <= wr_ptr + PTR_W'(accept);
      rd_ptr     <= rd_ptr + PTR_W'(mem_pop);
      count      <= count + (PTR_W+1)'(accept) - (PTR_W+1)'(mem_pop);
      drop_cnt_o <= drop_next;
    end
  end

  // Storage has no reset; only the occupied window is ever observed.
  always_ff @(posedge clk) begin
    if (!flush) begin
      if (accept != 2'd0)
        mem[wr_ptr] <= wr0_info;
      if (accept == 2'd2)
        mem[wr_ptr + PTR_W'(1)] <= bus.res1_info;
    end
  end

  assign count_o = count;

endmodule

// File: doc/branch_update_queue.md
Name: branch_update_queue

Overview:
- Sits between the EX stage and the branch predictor lite.
- Collects up to two resolved branches per cycle from the dual-issue EX stage and buffers them in an in-order FIFO.
- Presents at most one update per cycle to the predictor as a packed branch_info word.
- When no update is pending, it drives an all-zero word, which the predictor treats as "no update".

Parameters:
- DEPTH, 8: FIFO entries; power of two, minimum 4.
- PTR_W, 3: log2(DEPTH).
- INFO_W, 67: branch_info width; layout {pc[66:35], taken[34], target[33:2], btype[1:0]}.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- flush  in  1  synchronous clear of all queued entries
- res0_valid  in  1  slot0 resolved-branch valid (older)
- res0_info  in  INFO_W  slot0 packed outcome
- res1_valid  in  1  slot1 resolved-branch valid (younger)
- res1_info  in  INFO_W  slot1 packed outcome
- res_ready  out  1  EX may present two pushes this cycle
- upd_ready  in  1  predictor accepts the head this cycle (low during predictor stall)
- upd_valid  out  1  head entry valid
- branch_info_o  out  INFO_W  head entry; all zero when upd_valid=0
- count_o  out  PTR_W+1  occupied entries
- drop_cnt_o  out  16  saturating count of pushes dropped on overflow

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on resetn.
- Reset values:
  - rd_ptr = 0, wr_ptr = 0, count_o = 0
  - upd_valid = 0, branch_info_o = 0
  - res_ready = 1, drop_cnt_o = 0
- Storage: circular array of DEPTH×INFO_W, indexed by PTR_W-bit pointers that wrap modulo DEPTH. Occupancy counter is PTR_W+1 bits.
- Readiness: res_ready = (count_o <= DEPTH-2), evaluated on registered count only. Pushes in the same cycle are not counted.
- Push order: slot0 is written before slot1.
  - Both valid: slot0 goes to wr_ptr, slot1 to wr_ptr+1, and wr_ptr advances by 2.
  - Only res1_valid: slot1 goes to wr_ptr, and wr_ptr advances by 1.
- Pop: occurs when upd_valid && upd_ready; rd_ptr advances by 1.
- Simultaneous push and pop: count_next = count + pushes − pop. A pop in the same cycle frees space for that cycle's pushes.
- Overflow (EX ignores res_ready):
  - Pushes are accepted in order while free space exists, including space freed by a same-cycle pop.
  - Excess pushes are discarded. drop_cnt_o increments by the number discarded (1 or 2) and saturates at 16'hFFFF.
- Output latency, macro absent: entry written in cycle N appears on branch_info_o in cycle N+1 at the earliest. Outputs are driven from the head of the array.
  - upd_valid = (count_o != 0)
  - branch_info_o = upd_valid ? mem[rd_ptr] : 0
- Empty: upd_valid=0 and branch_info_o=0; any upd_ready is ignored.
- Full: count_o=DEPTH and res_ready=0; a pop still proceeds.
- flush:
  - Sets rd_ptr=wr_ptr=0 and count=0 on the next edge.
  - Pushes and pops in the flush cycle are discarded. drop_cnt_o is not incremented and is not cleared.
- resetn asserted mid-operation clears everything immediately. Memory contents are don't-care.
- Invalid entries are never enqueued; an all-zero res_info with valid=1 is enqueued as-is.

Optional Feature:
- Macro: BUQ_EMPTY_BYPASS_EN.
- Defined:
  - When count_o=0 and res0_valid=1 (or res1_valid=1 alone), the oldest valid incoming entry is driven combinationally on branch_info_o with upd_valid=1 in the same cycle.
  - If upd_ready=1 that cycle, the entry is consumed and not written. The second slot, if present, is written at wr_ptr.
  - When flush=1, bypass is suppressed.
- Not defined: no combinational path from res*_ to upd_ / branch_info_o. Minimum latency is 1 cycle.

Test Plan:
1. Reset: hold resetn=0 for 3 cycles → upd_valid=0, branch_info_o=0, count_o=0, res_ready=1, drop_cnt_o=0.
2. Single push then drain:
   - Stimulus: res0_valid=1 with pc=0x8000_0100, taken=1, target=0x8000_0200, btype=2'b01, upd_ready=1.
   - Macro absent: next cycle branch_info_o equals that word, and count_o returns to 0 one cycle later.
   - Macro defined: the word is visible the same cycle and count_o stays 0.
3. Dual push ordering: both slots valid with pcs 0x100 and 0x104, upd_ready=1 → outputs appear as 0x100 then 0x104 on consecutive cycles.
4. Fill and wrap:
   - upd_ready=0, four cycles of dual pushes → count_o=8, res_ready=0 once count_o reaches 7.
   - Then pop 3 and push 2 → count_o=7, and entries wrap past index 7 in order.
5. Overflow: at count_o=8, upd_ready=0, dual push → drop_cnt_o=2 and count_o stays 8. The same push with upd_ready=1 → 1 dropped, and the head pops.
6. Flush: with count_o=5, assert flush alongside a dual push and upd_ready=1 → next cycle count_o=0 and upd_valid=0, with drop_cnt_o unchanged.
